// File: rtl/vga_pkg.sv
// Shared display constants and the bouncing-rectangle state encoding.
package vga_pkg;

  localparam int VER_PIXELS = 600;
  localparam int RECT_H_DEF = 64;

  function automatic int floor_of(input int screen_h, input int rect_h);
    return screen_h - rect_h;
  endfunction

  // Lowest top-left y at which the default rectangle still fits on screen.
  localparam int FLOOR = floor_of(VER_PIXELS, RECT_H_DEF);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FALL = 3'd1,
    RISE = 3'd2,
    REST = 3'd3,
    HOLD = 3'd4
  } bounce_state_t;

endpackage

// File: rtl/tick_gen.sv
// Physics-update strobe: one-cycle pulse every TICK_CYCLES enabled cycles.
module tick_gen #(
  parameter int TICK_CYCLES = 650000
) (
  input  logic clk65MHz,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/draw_rect_bounce_ctl.sv
// Rectangle top-left position: follows the mouse, drops on click, bounces with
// damping on the floor and rests.
//
// state | meaning
// IDLE  | xpos/ypos track the mouse; a click above the floor launches
// FALL  | ypos grows by vel each tick, vel accelerates up to V_MAX
// RISE  | ypos shrinks by vel each tick, vel decelerates
// REST  | parked on the floor; a click moves to HOLD
// HOLD  | waiting for release before tracking the mouse again
module draw_rect_bounce_ctl
  import vga_pkg::*;
#(
  parameter int POS_W       = 12,
  parameter int VEL_W       = 8,
  parameter int SCREEN_H    = VER_PIXELS,
  parameter int RECT_H      = RECT_H_DEF,
  parameter int TICK_CYCLES = 650000,
  parameter int GRAVITY     = 1,
  parameter int V_MAX       = 32,
  parameter int DAMP_SHIFT  = 1,
  parameter int MIN_BOUNCE  = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk65MHz,
  input  logic             rst,
  input  logic             mouse_left,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic [POS_W-1:0] mouse_ypos,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             moving,
  output logic [CNT_W-1:0] bounce_cnt
);

  localparam logic [POS_W:0]   FLOOR_W = (POS_W+1)'(floor_of(SCREEN_H, RECT_H));
  localparam logic [POS_W-1:0] FLOOR_P = POS_W'(floor_of(SCREEN_H, RECT_H));
  localparam logic [VEL_W:0]   GRAV_W  = (VEL_W+1)'(GRAVITY);
  localparam logic [VEL_W:0]   VMAX_W  = (VEL_W+1)'(V_MAX);
  localparam logic [VEL_W-1:0] GRAV_V  = VEL_W'(GRAVITY);
  localparam logic [VEL_W-1:0] VMAX_V  = VEL_W'(V_MAX);
  localparam logic [VEL_W-1:0] MINB_V  = VEL_W'(MIN_BOUNCE);

  bounce_state_t    state;
  logic [VEL_W-1:0] vel;
  logic             left_d;
  logic             left_rise;
  logic             tick;

  logic [POS_W:0]   y_w;
  logic [POS_W:0]   v_w;
  logic [POS_W:0]   y_sum;
  logic [POS_W-1:0] y_dec;
  logic [VEL_W:0]   vel_inc;
  logic [VEL_W-1:0] vel_fall;
  logic [VEL_W-1:0] vel_bounce;

  assign left_rise = mouse_left & ~left_d;

  // One bit of headroom so ypos + vel can never wrap before the floor compare.
  assign y_w        = {1'b0, ypos};
  assign v_w        = (POS_W+1)'(vel);
  assign y_sum      = y_w + v_w;
  assign y_dec      = ypos - POS_W'(vel);
  assign vel_inc    = {1'b0, vel} + GRAV_W;
  assign vel_fall   = (vel_inc > VMAX_W) ? VMAX_V : vel_inc[VEL_W-1:0];
  assign vel_bounce = vel - (vel >> DAMP_SHIFT);

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk65MHz(clk65MHz),
    .rst     (rst),
    .en      ((state == FALL) || (state == RISE)),
    .tick    (tick)
  );

  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      left_d <= 1'b0;
    end else begin
      left_d <= mouse_left;
    end
  end

  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      xpos       <= '0;
      ypos       <= '0;
      vel        <= '0;
      bounce_cnt <= '0;
      moving     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          xpos <= mouse_xpos;
          ypos <= mouse_ypos;
          if (left_rise && ({1'b0, mouse_ypos} < FLOOR_W)) begin
            state      <= FALL;
            vel        <= '0;
            bounce_cnt <= '0;
            moving     <= 1'b1;
          end
        end
        FALL: begin
          if (tick) begin
            if (y_sum < FLOOR_W) begin
              ypos <= y_sum[POS_W-1:0];
              vel  <= vel_fall;
            end else begin
              ypos <= FLOOR_P;
              if (vel_bounce >= MINB_V) begin
                state <= RISE;
                vel   <= vel_bounce;
                if (bounce_cnt != '1) bounce_cnt <= bounce_cnt + 1'b1;
              end else begin
                state  <= REST;
                vel    <= '0;
                moving <= 1'b0;
              end
            end
          end
        end
        RISE: begin
          if (tick) begin
            if (vel <= GRAV_V) begin
              ypos  <= (y_w > v_w) ? y_dec : '0;
              vel   <= '0;
              state <= FALL;
            end else if (y_w <= v_w) begin
              ypos  <= '0;
              vel   <= '0;
              state <= FALL;
            end else begin
              ypos <= y_dec;
              vel  <= vel - GRAV_V;
            end
          end
        end
        REST: begin
          if (left_rise) state <= HOLD;
        end
        HOLD: begin
          if (!mouse_left) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_bounce_ctl.sv
// Directed bench for draw_rect_bounce_ctl with a 4-cycle physics tick.
module tb_draw_rect_bounce_ctl;

  localparam int POS_W = 12;
  localparam int CNT_W = 4;

  logic             clk65MHz;
  logic             rst;
  logic             mouse_left;
  logic [POS_W-1:0] mouse_xpos;
  logic [POS_W-1:0] mouse_ypos;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic             moving;
  logic [CNT_W-1:0] bounce_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  int fall_a [9] = '{500, 501, 503, 506, 510, 515, 521, 528, 536};
  int rise_a [4] = '{532, 529, 527, 526};
  int fall_b [5] = '{526, 527, 529, 532, 536};
  int tail_b [5] = '{534, 533, 533, 534, 536};
  int fall_c [4] = '{530, 531, 533, 536};
  int tail_c [5] = '{534, 533, 533, 534, 536};

  draw_rect_bounce_ctl #(
    .TICK_CYCLES(4)
  ) dut (
    .clk65MHz  (clk65MHz),
    .rst       (rst),
    .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .xpos      (xpos),
    .ypos      (ypos),
    .moving    (moving),
    .bounce_cnt(bounce_cnt)
  );

  initial clk65MHz = 1'b0;
  always #5 clk65MHz = ~clk65MHz;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk65MHz);
  endtask

  initial begin
    rst        = 1'b1;
    mouse_left = 1'b0;
    mouse_xpos = 12'd123;
    mouse_ypos = 12'd45;
    step(2);
    check_val("rst_xpos", xpos, 0);
    check_val("rst_ypos", ypos, 0);
    check_val("rst_moving", moving, 0);
    check_val("rst_cnt", bounce_cnt, 0);
    rst = 1'b0;

    // idle tracking
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd200;
    step(1);
    check_val("idle_xpos", xpos, 100);
    check_val("idle_ypos", ypos, 200);
    check_val("idle_moving", moving, 0);

    // press at the floor line is refused
    mouse_ypos = 12'd536;
    mouse_left = 1'b1;
    step(1);
    check_val("blk_ypos", ypos, 536);
    check_val("blk_moving", moving, 0);
    step(4);
    check_val("blk_moving_late", moving, 0);
    mouse_ypos = 12'd400;
    step(1);
    check_val("blk_track", ypos, 400);
    mouse_left = 1'b0;
    step(1);

    // launch from 500, button held through flight
    mouse_xpos = 12'd50;
    mouse_ypos = 12'd500;
    step(1);
    mouse_left = 1'b1;
    step(1);
    check_val("l500_ypos", ypos, 500);
    check_val("l500_moving", moving, 1);
    check_val("l500_cnt", bounce_cnt, 0);
    mouse_xpos = 12'd900;
    mouse_ypos = 12'd10;
    for (int i = 0; i < 9; i++) begin
      step(4);
      check_val($sformatf("fall_a%0d", i), ypos, fall_a[i]);
    end
    check_val("bounce1_cnt", bounce_cnt, 1);
    check_val("bounce1_moving", moving, 1);
    for (int i = 0; i < 4; i++) begin
      step(4);
      check_val($sformatf("rise_a%0d", i), ypos, rise_a[i]);
    end
    check_val("flight_xpos", xpos, 50);
    for (int i = 0; i < 5; i++) begin
      step(4);
      check_val($sformatf("fall_b%0d", i), ypos, fall_b[i]);
    end
    check_val("bounce2_cnt", bounce_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      step(4);
      check_val($sformatf("tail_b%0d", i), ypos, tail_b[i]);
    end
    check_val("rest_moving", moving, 0);
    check_val("rest_cnt", bounce_cnt, 2);

    // REST ignores the button held from flight; fresh press -> HOLD -> IDLE
    mouse_xpos = 12'd222;
    mouse_ypos = 12'd300;
    mouse_left = 1'b0;
    step(3);
    check_val("rest_hold_ypos", ypos, 536);
    check_val("rest_hold_xpos", xpos, 50);
    mouse_left = 1'b1;
    step(1);
    step(3);
    check_val("hold_ypos", ypos, 536);
    check_val("hold_moving", moving, 0);
    mouse_left = 1'b0;
    step(1);
    check_val("release_ypos", ypos, 536);
    step(1);
    check_val("idle_again_ypos", ypos, 300);
    check_val("idle_again_xpos", xpos, 222);

    // launch from 530: single bounce then rest
    mouse_ypos = 12'd530;
    mouse_left = 1'b1;
    step(1);
    check_val("l530_moving", moving, 1);
    check_val("l530_cnt", bounce_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      step(4);
      check_val($sformatf("fall_c%0d", i), ypos, fall_c[i]);
    end
    check_val("c_bounce_cnt", bounce_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      step(4);
      check_val($sformatf("tail_c%0d", i), ypos, tail_c[i]);
    end
    check_val("c_rest_moving", moving, 0);
    check_val("c_rest_cnt", bounce_cnt, 1);

    // back to IDLE, launch, then async reset mid-fall
    mouse_left = 1'b0;
    step(1);
    mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    mouse_xpos = 12'd77;
    mouse_ypos = 12'd100;
    step(1);
    step(1);
    check_val("pre_launch_ypos", ypos, 100);
    mouse_left = 1'b1;
    step(1);
    check_val("l100_moving", moving, 1);
    step(8);
    check_val("l100_fall", ypos, 101);
    #2;
    rst        = 1'b1;
    mouse_left = 1'b0;
    #1;
    check_val("arst_xpos", xpos, 0);
    check_val("arst_ypos", ypos, 0);
    check_val("arst_moving", moving, 0);
    check_val("arst_cnt", bounce_cnt, 0);
    step(1);
    rst = 1'b0;
    step(1);
    check_val("post_rst_ypos", ypos, 100);
    check_val("post_rst_xpos", xpos, 77);
    step(5);
    check_val("post_rst_moving", moving, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
